// File: rtl/dmem_responder_if.sv
// CPU data-memory bus between the MEM stage (master) and dmem_responder (slave).
interface dmem_responder_if;
   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_dout;
   logic [31:0] mem_din;

   modport master (output mem_ren, output mem_wen, output mem_addr, output mem_dout, input mem_din);
   modport slave  (input mem_ren, input mem_wen, input mem_addr, input mem_dout, output mem_din);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with combinational loads, clocked stores and a registered debug port.
// Define DMEM_MMIO_EN to add the MMIO block (LEDs, cycle counter, sticky store-error status).
module dmem_responder #(
   parameter int    ADDR_WIDTH = 10,
   parameter string INIT_FILE  = ""
) (
   input  logic                clk,
   input  logic                rst,
   dmem_responder_if.slave     mem,
   output logic [31:0]         leds,
   input  logic [6:0]          debug_addr,
   output logic [31:0]         debug_data
);

   logic [31:0]           ram [0:(1<<ADDR_WIDTH)-1];
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [ADDR_WIDTH-1:0] dbg_idx;
   logic                  wr_en;
   logic                  ram_sel;

   assign word_idx = mem.mem_addr[ADDR_WIDTH+1:2];
   assign dbg_idx  = ADDR_WIDTH'(debug_addr);
   assign wr_en    = mem.mem_wen && !rst;

   // RAM is deliberately left out of reset so program data survives a CPU reset
   always_ff @(posedge clk) begin
      if (wr_en && ram_sel) begin
         ram[word_idx] <= mem.mem_dout;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         debug_data <= '0;
      end else begin
         debug_data <= ram[dbg_idx];
      end
   end

`ifdef DMEM_MMIO_EN
   logic        io_sel;
   logic [1:0]  io_idx;
   logic [31:0] cycle_cnt;
   logic [1:0]  status;
   logic [1:0]  status_set;
   logic [1:0]  status_clr;
   logic        unused_addr;

   assign ram_sel     = (mem.mem_addr[31:28] == 4'h0);
   assign io_sel      = (mem.mem_addr[31:28] == 4'hF);
   assign io_idx      = mem.mem_addr[3:2];
   assign unused_addr = &{1'b0, mem.mem_addr[27:ADDR_WIDTH+2]};

   always_comb begin
      mem.mem_din = '0;
      if (mem.mem_ren) begin
         if (ram_sel) begin
            mem.mem_din = ram[word_idx];
         end else if (io_sel) begin
            case (io_idx)
               2'd0:    mem.mem_din = leds;
               2'd1:    mem.mem_din = cycle_cnt;
               2'd2:    mem.mem_din = {30'd0, status};
               default: mem.mem_din = '0;
            endcase
         end
      end
   end

   // A store aimed at the status register only clears; it never flags itself
   always_comb begin
      status_set = 2'b00;
      status_clr = 2'b00;
      if (wr_en) begin
         if (io_sel && io_idx == 2'd2) begin
            status_clr = mem.mem_dout[1:0];
         end else begin
            status_set[0] = (mem.mem_addr[1:0] != 2'b00);
            status_set[1] = !ram_sel && !io_sel;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         leds      <= '0;
         cycle_cnt <= '0;
         status    <= '0;
      end else begin
         if (wr_en && io_sel && io_idx == 2'd0) begin
            leds <= mem.mem_dout;
         end
         if (wr_en && io_sel && io_idx == 2'd1) begin
            cycle_cnt <= '0;
         end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
         end
         status <= (status & ~status_clr) | status_set;
      end
   end
`else
   logic unused_addr;

   assign ram_sel     = 1'b1;
   assign leds        = '0;
   assign unused_addr = &{1'b0, mem.mem_addr[31:ADDR_WIDTH+2], mem.mem_addr[1:0]};

   always_comb begin
      mem.mem_din = '0;
      if (mem.mem_ren) begin
         mem.mem_din = ram[word_idx];
      end
   end
`endif

endmodule
